// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_pwm
//  Description : Per-LED linear fade with a shared PWM counter. Drives the
//                board LED pins from the led_2soc register outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade_pwm #(
   parameter int N_LED    = 24,
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 4096
) (
   input  logic             clk_from_bg,
   input  logic             rst_from_bg,
   input  logic [N_LED-1:0] led_2soc,
   input  logic             fade_en,
   output logic [N_LED-1:0] led_out,
   output logic             busy
);

   localparam logic [PWM_BITS-1:0] c_MAX       = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] c_PWM_LAST  = c_MAX - 1'b1;
   localparam int                  c_STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_DIV - 1);

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [c_STEP_W-1:0] r_step_cnt;
   logic                w_tick;
   logic [PWM_BITS-1:0] r_level [N_LED];
   logic [PWM_BITS-1:0] w_next  [N_LED];
   logic [N_LED-1:0]    w_mismatch;
   logic [N_LED-1:0]    r_led_out;

   always_ff @(posedge clk_from_bg) begin
      if (!rst_from_bg) begin
         r_pwm_cnt  <= '0;
         r_step_cnt <= '0;
      end else begin
         r_pwm_cnt  <= (r_pwm_cnt == c_PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
         r_step_cnt <= (r_step_cnt == c_STEP_LAST) ? '0 : r_step_cnt + 1'b1;
      end
   end

   assign w_tick = (r_step_cnt == c_STEP_LAST);

   generate
      for (genvar gi = 0; gi < N_LED; gi++) begin : g_chan
         logic [PWM_BITS-1:0] w_tgt;
         logic                w_up;
         logic                w_dn;

         assign w_tgt = led_2soc[gi] ? c_MAX : '0;
         assign w_up  = (r_level[gi] < w_tgt);
         assign w_dn  = (r_level[gi] > w_tgt);

         // The compares guarantee +1/-1 never leave 0..MAX.
         assign w_next[gi] = !fade_en          ? w_tgt :
                             (w_tick && w_up)  ? r_level[gi] + 1'b1 :
                             (w_tick && w_dn)  ? r_level[gi] - 1'b1 :
                                                 r_level[gi];

         assign w_mismatch[gi] = (r_level[gi] != w_tgt);
      end
   endgenerate

   always_ff @(posedge clk_from_bg) begin
      if (!rst_from_bg) begin
         for (int i = 0; i < N_LED; i++) begin
            r_level[i] <= '0;
         end
         r_led_out <= '0;
      end else begin
         for (int i = 0; i < N_LED; i++) begin
            r_level[i]   <= w_next[i];
            r_led_out[i] <= (r_level[i] > r_pwm_cnt);
         end
      end
   end

   assign led_out = r_led_out;
   assign busy    = |w_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade_pwm
//  Description : Self-checking bench for led_fade_pwm with an arithmetic
//                reference model and randomized target/mode stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade_pwm;

   localparam int c_N    = 24;
   localparam int c_MAXV = 255;
   localparam int c_SD   = 4;

   logic          clk_from_bg = 1'b0;
   logic          rst_from_bg;
   logic [c_N-1:0] led_2soc;
   logic          fade_en;
   logic [c_N-1:0] led_out;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   // Reference state: brightness per LED and cycles elapsed since reset release.
   int            m_lvl [c_N];
   int            m_n;
   logic [c_N-1:0] m_led;
   logic          m_busy;

   led_fade_pwm #(
      .N_LED   (c_N),
      .PWM_BITS(8),
      .STEP_DIV(c_SD)
   ) u_dut (
      .clk_from_bg(clk_from_bg),
      .rst_from_bg(rst_from_bg),
      .led_2soc   (led_2soc),
      .fade_en    (fade_en),
      .led_out    (led_out),
      .busy       (busy)
   );

   always #5 clk_from_bg = ~clk_from_bg;

   function automatic int target_of(input int i);
      return led_2soc[i] ? c_MAXV : 0;
   endfunction

   function automatic logic model_busy();
      for (int i = 0; i < c_N; i++) begin
         if (m_lvl[i] != target_of(i)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advance plus per-cycle comparison against the DUT outputs.
   always @(posedge clk_from_bg) begin
      if (!rst_from_bg) begin
         m_n   = 0;
         m_led = '0;
         for (int i = 0; i < c_N; i++) m_lvl[i] = 0;
      end else begin
         for (int i = 0; i < c_N; i++) m_led[i] = (m_lvl[i] > (m_n % c_MAXV));
         for (int i = 0; i < c_N; i++) begin
            if (!fade_en)
               m_lvl[i] = target_of(i);
            else if ((m_n % c_SD) == c_SD - 1) begin
               if (m_lvl[i] < target_of(i))      m_lvl[i] = m_lvl[i] + 1;
               else if (m_lvl[i] > target_of(i)) m_lvl[i] = m_lvl[i] - 1;
            end
         end
         m_n++;
      end
      #1;
      m_busy = model_busy();
      check("led_out_model", 32'(led_out), 32'(m_led));
      check("busy_model", 32'(busy), 32'(m_busy));
   end

   task automatic settle_after_edge();
      @(posedge clk_from_bg);
      #2;
   endtask

   task automatic apply_reset(input logic [c_N-1:0] tgt, input logic fe, input int cycles);
      @(negedge clk_from_bg);
      rst_from_bg = 1'b0;
      led_2soc    = tgt;
      fade_en     = fe;
      repeat (cycles) @(negedge clk_from_bg);
      rst_from_bg = 1'b1;
   endtask

   // Counts edges from now until busy reads low, bounded.
   task automatic edges_to_idle(input string name, input int expect_edges);
      int cnt;
      cnt = 0;
      do begin
         settle_after_edge();
         cnt++;
      end while (busy && cnt < 3000);
      check(name, 32'(cnt), 32'(expect_edges));
   endtask

   task automatic wait_level(input int led, input int lvl);
      int guard;
      guard = 0;
      while (m_lvl[led] != lvl && guard < 3000) begin
         @(negedge clk_from_bg);
         guard++;
      end
      check("wait_level_reached", 32'(m_lvl[led]), 32'(lvl));
   endtask

   initial begin
      rst_from_bg = 1'b0;
      led_2soc    = '1;
      fade_en     = 1'b1;

      // Reset holds everything low even with all targets on.
      repeat (3) begin
         @(negedge clk_from_bg);
         check("reset_led_out", 32'(led_out), 32'h0);
      end
      rst_from_bg = 1'b1;
      settle_after_edge();
      check("release_busy", 32'(busy), 32'h1);
      check("release_led_out", 32'(led_out), 32'h0);

      // Fade LED0 up from zero: 255 steps of 4 cycles.
      apply_reset(24'h000001, 1'b1, 2);
      edges_to_idle("fade_up_edges", 1020);
      settle_after_edge();
      settle_after_edge();
      check("fade_up_full_on", 32'(led_out), 32'h000001);

      // Instant mode jump.
      @(negedge clk_from_bg);
      fade_en  = 1'b0;
      led_2soc = '0;
      repeat (3) @(negedge clk_from_bg);
      led_2soc = '1;
      #1;
      check("instant_busy_T", 32'(busy), 32'h1);
      settle_after_edge();
      check("instant_busy_T1", 32'(busy), 32'h0);
      settle_after_edge();
      check("instant_led_T2", 32'(led_out), 32'hFFFFFF);
      repeat (300) begin
         settle_after_edge();
         check("instant_led_hold", 32'(led_out), 32'hFFFFFF);
      end

      // Reversal of LED3 at level 100.
      apply_reset(24'h000008, 1'b1, 1);
      wait_level(3, 100);
      led_2soc = '0;
      edges_to_idle("reversal_edges", 400);
      check("reversal_led_off", 32'(led_out), 32'h0);

      // Reset pulse at level 150 restarts the fade from zero.
      apply_reset(24'h000001, 1'b1, 1);
      wait_level(0, 150);
      rst_from_bg = 1'b0;
      settle_after_edge();
      check("midreset_led_out", 32'(led_out), 32'h0);
      check("midreset_busy", 32'(busy), 32'h1);
      @(negedge clk_from_bg);
      rst_from_bg = 1'b1;
      edges_to_idle("midreset_refade_edges", 1020);

      // Randomized targets, mode switches and occasional resets.
      for (int seg = 0; seg < 40; seg++) begin
         @(negedge clk_from_bg);
         if ($urandom_range(0, 9) == 0) begin
            rst_from_bg = 1'b0;
            @(negedge clk_from_bg);
            rst_from_bg = 1'b1;
         end
         led_2soc = 24'($urandom);
         fade_en  = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 300)) @(negedge clk_from_bg);
      end

      settle_after_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
